cpri_chip_deframer: RTL
=======================

Name: cpri_chip_deframer

Overview:
- Consumes the 8-lane, 64-bit CPRI PRB stream and its per-chip start-of-packet strobe, as produced by the CPRI PRB combination generator.
- Locks to the strobe's 96-cycle chip period through a hunt/check/lock FSM and registers the lane data.
- Tags every word with its cycle-in-chip, chip-in-symbol and symbol indices, and raises a valid flag for the active symbol.
- Feeds the PUSCH dimension-reduction datapath, which needs stable chip and symbol boundaries.

Parameters:
- DAT_DW, 64, width of each lane word.
- CHIP_LEN, 96, cycles per chip; the expected spacing between sop_i pulses.
- CHIPS_PER_SYM, 462, chips per symbol (462 x 96 = 44352 cycles).
- SYM_PER_GRP, 5, symbols per group; symbol index wraps after SYM_PER_GRP-1.
- ACT_SYM, 0, symbol index on which dat_vld_o is asserted.
- SOP_OFS, 2, cycles from an accepted sop_i to the chip's first data word (cyc_idx 0).
- LOCK_CNT, 3, consecutive correctly spaced sop_i pulses needed to enter LOCK.
- UNLOCK_CNT, 2, consecutive bad or missing sop_i events in LOCK that force HUNT.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- sop_i, in, 1, chip start strobe; one-cycle pulse.
- dat_cpri0_i .. dat_cpri7_i, in, DAT_DW each, lane data.
- dat0_o .. dat7_o, out, DAT_DW each, registered lane data.
- dat_vld_o, out, 1, locked and sym_idx_o == ACT_SYM.
- chip_sop_o, out, 1, high on the word with cyc_idx_o == 0 while locked.
- cyc_idx_o, out, 7, 0..CHIP_LEN-1.
- chip_idx_o, out, 9, 0..CHIPS_PER_SYM-1.
- sym_idx_o, out, 3, 0..SYM_PER_GRP-1.
- lock_o, out, 1, FSM is in LOCK.
- err_cnt_o, out, 16, saturating count of sop_i spacing errors seen in LOCK.

Behaviour:
- Reset: rst_n is asynchronous and active low. While rst_n is low, all outputs are 0, the FSM is in HUNT, and all counters are 0. The first sop_i is sampled on the first clk edge after rst_n rises.
- Spacing counter sp_cnt:
  - Cleared to 0 on every sop_i that is accepted (the first pulse in HUNT, and any pulse in CHECK).
  - Otherwise increments and saturates at CHIP_LEN.
  - A pulse is "good" when it arrives with sp_cnt == CHIP_LEN-1; any other arrival is "bad". A good pulse is therefore exactly CHIP_LEN cycles after the previous one.
- FSM HUNT: on sop_i, clear sp_cnt and go to CHECK with good_cnt = 0.
- FSM CHECK:
  - Good sop_i: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCK.
  - Bad sop_i: stay in CHECK, set good_cnt = 0, and take this pulse as the new timing reference.
  - sp_cnt reaching CHIP_LEN with no sop_i: go to HUNT.
- FSM LOCK:
  - Timing is free-running: cyc_idx advances every cycle, modulo CHIP_LEN.
  - On the cycle where a sop_i is expected, a correctly timed sop_i clears bad_cnt.
  - A bad sop_i and a missing expected sop_i are each one event: bad_cnt++ and err_cnt_o++. err_cnt_o saturates at 0xFFFF.
  - When bad_cnt reaches UNLOCK_CNT, go to HUNT.
  - When several events coincide, the HUNT transition wins.
- Index counters:
  - On entry to LOCK, the first data word lands SOP_OFS cycles after the locking sop_i. That word gets cyc_idx = 0, chip_idx = 0, sym_idx = 0.
  - cyc_idx wraps from CHIP_LEN-1 to 0 and then increments chip_idx.
  - chip_idx wraps from CHIPS_PER_SYM-1 to 0 and then increments sym_idx.
  - sym_idx wraps from SYM_PER_GRP-1 to 0.
  - Loss of lock freezes all three indices and clears lock_o, dat_vld_o and chip_sop_o on the next cycle.
- Data path:
  - dat*_o is dat_cpri*_i registered once: latency 1 cycle.
  - Index, valid and sop outputs are registered so they line up with the data word they describe.
- lock_o rises on the cycle the chip_sop_o for cyc_idx 0 is first asserted.

Optional Feature:
- Macro: CPRI_DEFRM_UNLOCK_ZERO_EN.
- Defined: dat0_o..dat7_o are forced to 0 whenever lock_o is 0.
- Undefined: data is passed through in every state and only the flags indicate validity.

Test Plan:
1. Clean stream: release reset, drive sop_i every 96 cycles with lane n = {n, counter}.
   - lock_o rises after the 4th pulse (first + 3 good).
   - chip_sop_o arrives 2 cycles after that pulse; cyc_idx_o runs 0..95.
   - dat_vld_o is high for the first 44352 locked cycles, low for the next 4 x 44352, then repeats.
2. Wrap check: after lock, run 2 full groups (5 x 44352 cycles each).
   - chip_idx_o wraps 461->0; sym_idx_o wraps 4->0.
   - err_cnt_o stays 0.
3. One sop_i shifted to cycle 97 while locked:
   - err_cnt_o = 2 (missing at 96, bad at 97); lock_o falls.
   - Relock occurs after 3 further good pulses.
4. Single sop_i dropped while locked, then the stream resumes:
   - err_cnt_o = 1, lock_o stays 1, indices continue.
5. Glitch pulse in CHECK at spacing 50:
   - good_cnt resets and the glitch becomes the reference.
   - Lock needs 3 more 96-spaced pulses measured from the glitch.
6. Assert rst_n low mid-chip (cyc_idx 40) for 1 cycle:
   - All outputs go to 0 without waiting for a clk edge; the FSM returns to HUNT.
   - With CPRI_DEFRM_UNLOCK_ZERO_EN defined, data reads 0 until relock; without it, data passes through.

Source files
------------

// File: rtl/cpri_chip_deframer.sv
// Chip deframer: locks to the 96-cycle sop_i cadence of the 8-lane CPRI PRB stream and tags each word with its indices.
// Optional macro CPRI_DEFRM_UNLOCK_ZERO_EN: zero the lane outputs whenever lock_o is low.
module cpri_chip_deframer #(
    parameter int DAT_DW        = 64,
    parameter int CHIP_LEN      = 96,
    parameter int CHIPS_PER_SYM = 462,
    parameter int SYM_PER_GRP   = 5,
    parameter int ACT_SYM       = 0,
    parameter int SOP_OFS       = 2,
    parameter int LOCK_CNT      = 3,
    parameter int UNLOCK_CNT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sop_i,
    input  logic [DAT_DW-1:0] dat_cpri0_i,
    input  logic [DAT_DW-1:0] dat_cpri1_i,
    input  logic [DAT_DW-1:0] dat_cpri2_i,
    input  logic [DAT_DW-1:0] dat_cpri3_i,
    input  logic [DAT_DW-1:0] dat_cpri4_i,
    input  logic [DAT_DW-1:0] dat_cpri5_i,
    input  logic [DAT_DW-1:0] dat_cpri6_i,
    input  logic [DAT_DW-1:0] dat_cpri7_i,
    output logic [DAT_DW-1:0] dat0_o,
    output logic [DAT_DW-1:0] dat1_o,
    output logic [DAT_DW-1:0] dat2_o,
    output logic [DAT_DW-1:0] dat3_o,
    output logic [DAT_DW-1:0] dat4_o,
    output logic [DAT_DW-1:0] dat5_o,
    output logic [DAT_DW-1:0] dat6_o,
    output logic [DAT_DW-1:0] dat7_o,
    output logic              dat_vld_o,
    output logic              chip_sop_o,
    output logic [6:0]        cyc_idx_o,
    output logic [8:0]        chip_idx_o,
    output logic [2:0]        sym_idx_o,
    output logic              lock_o,
    output logic [15:0]       err_cnt_o
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    localparam int SPW = $clog2(CHIP_LEN + 1);
    localparam int GW  = $clog2(LOCK_CNT + 1);
    localparam int BW  = $clog2(UNLOCK_CNT + 1);

    localparam logic [SPW-1:0] SP_LAST  = SPW'(CHIP_LEN - 1);
    localparam logic [SPW-1:0] SP_SAT   = SPW'(CHIP_LEN);
    // SOP_OFS >= 2: the locking pulse cycle plus the output register account for two cycles
    localparam logic [SPW-1:0] SP_START = SPW'(SOP_OFS - 2);
    localparam logic [GW-1:0]  GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [BW-1:0]  BAD_MAX  = BW'(UNLOCK_CNT);
    localparam logic [6:0]     CYC_LAST  = 7'(CHIP_LEN - 1);
    localparam logic [8:0]     CHIP_LAST = 9'(CHIPS_PER_SYM - 1);
    localparam logic [2:0]     SYM_LAST  = 3'(SYM_PER_GRP - 1);
    localparam logic [2:0]     SYM_ACT   = 3'(ACT_SYM);

    state_t          state_q, state_d;
    logic [SPW-1:0]  sp_cnt_q, sp_cnt_d;
    logic [GW-1:0]   good_q, good_d;
    logic [BW-1:0]   bad_q, bad_d;
    logic [15:0]     err_q, err_d;

    logic            run_q, run_d;
    logic [6:0]      cyc_q, cyc_d;
    logic [8:0]      chip_q, chip_d;
    logic [2:0]      sym_q, sym_d;
    logic            lock_q, lock_d;
    logic            vld_q, vld_d;
    logic            csop_q, csop_d;

    logic [SPW-1:0]  sp_inc;
    logic [GW-1:0]   good_inc;
    logic [BW-1:0]   bad_inc;
    logic            slot;
    logic            lock_evt;

    always_comb begin
        state_d  = state_q;
        sp_cnt_d = sp_cnt_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = err_q;
        sp_inc   = (sp_cnt_q == SP_SAT) ? SP_SAT : sp_cnt_q + 1'b1;
        good_inc = good_q + 1'b1;
        bad_inc  = bad_q + 1'b1;
        slot     = (sp_cnt_q == SP_LAST);
        lock_evt = 1'b0;
        case (state_q)
            HUNT: begin
                sp_cnt_d = sp_inc;
                if (sop_i) begin
                    sp_cnt_d = '0;
                    good_d   = '0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                sp_cnt_d = sp_inc;
                if (sop_i) begin
                    sp_cnt_d = '0;
                    if (slot) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_MAX) begin
                            good_d  = '0;
                            bad_d   = '0;
                            state_d = LOCK;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (slot) begin
                    state_d = HUNT;
                end
            end
            LOCK: begin
                // Cadence is free-running here: a stray pulse never re-centres sp_cnt
                sp_cnt_d = slot ? '0 : sp_cnt_q + 1'b1;
                lock_evt = slot ? !sop_i : sop_i;
                if (slot && sop_i) begin
                    bad_d = '0;
                end
                if (lock_evt) begin
                    bad_d = bad_inc;
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (bad_inc == BAD_MAX) begin
                        bad_d   = '0;
                        state_d = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        run_d  = run_q;
        cyc_d  = cyc_q;
        chip_d = chip_q;
        sym_d  = sym_q;
        lock_d = 1'b0;
        vld_d  = 1'b0;
        csop_d = 1'b0;
        if (state_d != LOCK) begin
            run_d = 1'b0;
        end else if (run_q) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (chip_q == CHIP_LAST) begin
                    chip_d = '0;
                    sym_d  = (sym_q == SYM_LAST) ? 3'd0 : sym_q + 3'd1;
                end else begin
                    chip_d = chip_q + 9'd1;
                end
            end else begin
                cyc_d = cyc_q + 7'd1;
            end
            lock_d = 1'b1;
            csop_d = (cyc_d == 7'd0);
            vld_d  = (sym_d == SYM_ACT);
        end else if (state_q == LOCK && sp_cnt_q == SP_START) begin
            // First word of the locking chip reaches the output on this edge
            run_d  = 1'b1;
            cyc_d  = '0;
            chip_d = '0;
            sym_d  = '0;
            lock_d = 1'b1;
            csop_d = 1'b1;
            vld_d  = (SYM_ACT == 3'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            sp_cnt_q <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            err_q    <= '0;
            run_q    <= 1'b0;
            cyc_q    <= '0;
            chip_q   <= '0;
            sym_q    <= '0;
            lock_q   <= 1'b0;
            vld_q    <= 1'b0;
            csop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_cnt_q <= sp_cnt_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            run_q    <= run_d;
            cyc_q    <= cyc_d;
            chip_q   <= chip_d;
            sym_q    <= sym_d;
            lock_q   <= lock_d;
            vld_q    <= vld_d;
            csop_q   <= csop_d;
        end
    end

    logic [DAT_DW-1:0] lane_in [8];
    logic [DAT_DW-1:0] dat_q   [8];
    logic [DAT_DW-1:0] dat_out [8];

    assign lane_in[0] = dat_cpri0_i;
    assign lane_in[1] = dat_cpri1_i;
    assign lane_in[2] = dat_cpri2_i;
    assign lane_in[3] = dat_cpri3_i;
    assign lane_in[4] = dat_cpri4_i;
    assign lane_in[5] = dat_cpri5_i;
    assign lane_in[6] = dat_cpri6_i;
    assign lane_in[7] = dat_cpri7_i;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_q[gi] <= '0;
                end else begin
                    dat_q[gi] <= lane_in[gi];
                end
            end
`ifdef CPRI_DEFRM_UNLOCK_ZERO_EN
            assign dat_out[gi] = lock_q ? dat_q[gi] : '0;
`else
            assign dat_out[gi] = dat_q[gi];
`endif
        end
    endgenerate

    assign dat0_o     = dat_out[0];
    assign dat1_o     = dat_out[1];
    assign dat2_o     = dat_out[2];
    assign dat3_o     = dat_out[3];
    assign dat4_o     = dat_out[4];
    assign dat5_o     = dat_out[5];
    assign dat6_o     = dat_out[6];
    assign dat7_o     = dat_out[7];
    assign dat_vld_o  = vld_q;
    assign chip_sop_o = csop_q;
    assign cyc_idx_o  = cyc_q;
    assign chip_idx_o = chip_q;
    assign sym_idx_o  = sym_q;
    assign lock_o     = lock_q;
    assign err_cnt_o  = err_q;

endmodule
